// File: rtl/neuron_spike_out_arbiter.sv
// Round-robin arbiter and write sequencer feeding the single-word spike-out register.
// Optional accepted-word counter is enabled with the SPIKE_ARB_CNT_EN macro.
module neuron_spike_out_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        enable_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [32*NUM_REQ-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        bus_busy_i,
    output logic [31:0]                 spike_data_o,
    output logic                        spike_write_en_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic [15:0]                 spike_count_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand;
    logic              gnt_found;
    logic              grant;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [0:0]        state_q;
    logic [0:0]        state_d;

    // Round-robin search starting one past the last granted core
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Full FIFO blocks grants even when a pop frees a slot this cycle
    always_comb begin
        grant       = enable_i & ~wb_rst_i & gnt_found &
                      (fifo_count_o < CNT_W'(FIFO_DEPTH));
        req_ready_o = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign push = grant;
    assign pop  = (fifo_count_o != '0) & ~bus_busy_i;

    always_comb begin
        push_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                push_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                last_grant <= gnt_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_o <= fifo_count_o + CNT_W'(1);
                2'b01:   fifo_count_o <= fifo_count_o - CNT_W'(1);
                default: fifo_count_o <= fifo_count_o;
            endcase
        end
    end

    // Write sequencer: WRITE holds for exactly the cycles that follow a pop
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = pop ? S_WRITE : S_IDLE;
            S_WRITE: state_d = pop ? S_WRITE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign spike_write_en_o = (state_q == S_WRITE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            spike_data_o <= '0;
        end else if (pop) begin
            spike_data_o <= mem[rd_ptr];
        end
    end

`ifdef SPIKE_ARB_CNT_EN
    // Saturating count of accepted words
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            spike_count_o <= '0;
        end else if (push && (spike_count_o != 16'hFFFF)) begin
            spike_count_o <= spike_count_o + 16'd1;
        end
    end
`else
    assign spike_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_neuron_spike_out_arbiter.sv
// Scoreboard bench for neuron_spike_out_arbiter: expected words queued at accept, checked at strobe.
module tb_neuron_spike_out_arbiter;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic                  wb_clk_i;
    logic                  wb_rst_i;
    logic                  enable_i;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [32*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic                  bus_busy_i;
    logic [31:0]           spike_data_o;
    logic                  spike_write_en_o;
    logic [2:0]            fifo_count_o;
    logic [15:0]           spike_count_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b1;
    exp_t sb[$];
    exp_t mon_e;

    neuron_spike_out_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .enable_i        (enable_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .bus_busy_i      (bus_busy_i),
        .spike_data_o    (spike_data_o),
        .spike_write_en_o(spike_write_en_o),
        .fifo_count_o    (fifo_count_o),
        .spike_count_o   (spike_count_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Scoreboard pop on every strobe
    always @(negedge wb_clk_i) begin
        if (mon_en && spike_write_en_o === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got data %h at cycle %0d, nothing expected", spike_data_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (spike_data_o !== mon_e.data || (mon_e.due >= 0 && cyc != mon_e.due)) begin
                    n_fail++;
                    $display("FAIL strobe_data: got %h at cycle %0d, expected %h at cycle %0d",
                             spike_data_o, cyc, mon_e.data, mon_e.due);
                end
            end
        end
    end

    task automatic test_reset();
        wb_rst_i    = 1'b1;
        enable_i    = 1'b1;
        bus_busy_i  = 1'b0;
        req_valid_i = 4'b1111;
        req_data_i  = '0;
        repeat (3) @(negedge wb_clk_i);
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000 || spike_data_o !== 32'h0 || spike_write_en_o !== 1'b0 ||
            fifo_count_o !== 3'd0 || spike_count_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b data=%h wen=%b cnt=%0d sc=%0d, expected all 0",
                     req_ready_o, spike_data_o, spike_write_en_o, fifo_count_o, spike_count_o);
        end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_grant: got %b, expected 0001", req_ready_o);
        end
        enable_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [31:0] words [4];
        exp_t        ent;
        words[0] = 32'hA0; words[1] = 32'hB1; words[2] = 32'hC2; words[3] = 32'hD3;
        for (int k = 0; k < 4; k++) req_data_i[32*k +: 32] = words[k];
        for (int i = 0; i < 12; i++) begin
            @(negedge wb_clk_i);
            enable_i    = 1'b1;
            req_valid_i = 4'b1111;
            #1;
            n_checks++;
            if (req_ready_o !== 4'(1 << (i % 4))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", i, req_ready_o, 4'(1 << (i % 4)));
            end
            ent.data = words[i % 4];
            ent.due  = cyc + 2;
            sb.push_back(ent);
        end
        @(negedge wb_clk_i);
        req_valid_i = 4'b0000;
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge wb_clk_i);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: %0d words never strobed, expected 0", sb.size());
        end
    endtask

    task automatic test_busy_hold();
        exp_t ent;
        int   acc = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge wb_clk_i);
            bus_busy_i            = 1'b1;
            req_valid_i           = 4'b0100;
            req_data_i[64 +: 32]  = 32'h100 + 32'(acc);
            #1;
            n_checks++;
            if (req_ready_o !== ((acc < 4) ? 4'b0100 : 4'b0000) || fifo_count_o !== 3'(acc) ||
                spike_write_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_cycle[%0d]: got rdy=%b cnt=%0d wen=%b, expected rdy=%b cnt=%0d wen=0",
                         j, req_ready_o, fifo_count_o, spike_write_en_o,
                         (acc < 4) ? 4'b0100 : 4'b0000, acc);
            end
            if (acc < 4) begin
                ent.data = 32'h100 + 32'(acc);
                ent.due  = -1;
                sb.push_back(ent);
                acc++;
            end
        end
        @(negedge wb_clk_i);
        bus_busy_i  = 1'b0;
        req_valid_i = 4'b0000;
        #1;
        n_checks++;
        if (spike_write_en_o !== 1'b0 || fifo_count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL busy_release: got wen=%b cnt=%0d, expected wen=0 cnt=4", spike_write_en_o, fifo_count_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge wb_clk_i);
            #1;
            n_checks++;
            if (spike_write_en_o !== 1'b1 || fifo_count_o !== 3'(3 - k)) begin
                n_fail++;
                $display("FAIL busy_drain[%0d]: got wen=%b cnt=%0d, expected wen=1 cnt=%0d",
                         k, spike_write_en_o, fifo_count_o, 3 - k);
            end
        end
        @(negedge wb_clk_i);
        #1;
        n_checks++;
        if (spike_write_en_o !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL busy_end: got wen=%b pending=%0d, expected wen=0 pending=0", spike_write_en_o, sb.size());
        end
    endtask

    task automatic test_full_pop();
        exp_t ent;
        int   acc = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge wb_clk_i);
            bus_busy_i          = 1'b1;
            req_valid_i         = 4'b0001;
            req_data_i[0 +: 32] = 32'h200 + 32'(acc);
            #1;
            n_checks++;
            if (req_ready_o !== ((acc < 4) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL fill_grant[%0d]: got %b, expected %b", j, req_ready_o,
                         (acc < 4) ? 4'b0001 : 4'b0000);
            end
            if (acc < 4) begin
                ent.data = 32'h200 + 32'(acc);
                ent.due  = -1;
                sb.push_back(ent);
                acc++;
            end
        end
        @(negedge wb_clk_i);
        bus_busy_i          = 1'b0;
        req_data_i[0 +: 32] = 32'h200 + 32'(acc);
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000 || fifo_count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL full_pop_no_grant: got rdy=%b cnt=%0d, expected rdy=0000 cnt=4", req_ready_o, fifo_count_o);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge wb_clk_i);
            req_data_i[0 +: 32] = 32'h200 + 32'(acc);
            #1;
            n_checks++;
            if (req_ready_o !== 4'b0001 || fifo_count_o !== 3'd3) begin
                n_fail++;
                $display("FAIL full_resume[%0d]: got rdy=%b cnt=%0d, expected rdy=0001 cnt=3",
                         j, req_ready_o, fifo_count_o);
            end
            ent.data = 32'h200 + 32'(acc);
            ent.due  = -1;
            sb.push_back(ent);
            acc++;
        end
        @(negedge wb_clk_i);
        req_valid_i = 4'b0000;
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge wb_clk_i);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: %0d words never strobed, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t ent;
        for (int j = 0; j < 4; j++) begin
            @(negedge wb_clk_i);
            bus_busy_i           = 1'b1;
            req_valid_i          = 4'b0010;
            req_data_i[32 +: 32] = 32'h300 + 32'(j);
            #1;
            n_checks++;
            if (req_ready_o !== 4'b0010) begin
                n_fail++;
                $display("FAIL mid_fill[%0d]: got %b, expected 0010", j, req_ready_o);
            end
            ent.data = 32'h300 + 32'(j);
            ent.due  = -1;
            sb.push_back(ent);
        end
        @(negedge wb_clk_i);
        req_valid_i = 4'b0000;
        bus_busy_i  = 1'b0;
        @(negedge wb_clk_i);
        #1;
        n_checks++;
        if (spike_write_en_o !== 1'b1 || fifo_count_o !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got wen=%b cnt=%0d, expected wen=1 cnt=3", spike_write_en_o, fifo_count_o);
        end
        wb_rst_i = 1'b1;
        #1;
        n_checks++;
        if (spike_write_en_o !== 1'b0 || fifo_count_o !== 3'd0 || spike_data_o !== 32'h0 ||
            req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got wen=%b cnt=%0d data=%h rdy=%b, expected all 0",
                     spike_write_en_o, fifo_count_o, spike_data_o, req_ready_o);
        end
        sb.delete();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge wb_clk_i);
            #1;
            n_checks++;
            if (spike_write_en_o !== 1'b0 || fifo_count_o !== 3'd0) begin
                n_fail++;
                $display("FAIL mid_after[%0d]: got wen=%b cnt=%0d, expected wen=0 cnt=0",
                         j, spike_write_en_o, fifo_count_o);
            end
        end
        @(negedge wb_clk_i);
        req_valid_i = 4'b1111;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_priority: got %b, expected 0001", req_ready_o);
        end
        req_valid_i = 4'b0000;
    endtask

    task automatic test_spike_count();
        logic [15:0] exp_cnt;
        mon_en = 1'b0;
        @(negedge wb_clk_i);
        #1;
        n_checks++;
        if (spike_count_o !== 16'h0) begin
            n_fail++;
            $display("FAIL count_start: got %h, expected 0000", spike_count_o);
        end
        @(negedge wb_clk_i);
        req_valid_i = 4'b1111;
        repeat (100) @(negedge wb_clk_i);
        req_valid_i = 4'b0000;
        #1;
`ifdef SPIKE_ARB_CNT_EN
        exp_cnt = 16'd100;
`else
        exp_cnt = 16'd0;
`endif
        n_checks++;
        if (spike_count_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL count_100: got %h, expected %h", spike_count_o, exp_cnt);
        end
`ifdef SPIKE_ARB_CNT_EN
        req_valid_i = 4'b1111;
        repeat (69900) @(negedge wb_clk_i);
        req_valid_i = 4'b0000;
        #1;
        n_checks++;
        if (spike_count_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL count_saturate: got %h, expected FFFF", spike_count_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_busy_hold();
        test_full_pop();
        test_reset_mid();
        test_spike_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
